// File: rtl/nts_api_arbiter.sv
// Two-requester round-robin arbiter that shares the 12-bit NTS register API.
// Define NTS_API_ARBITER_LOCK_EN to let a requester hold the grant across transactions.
module nts_api_arbiter #(
  parameter int API_READ_LATENCY = 1
) (
  input  logic        i_clk,
  input  logic        i_areset_n,
  input  logic        i_a_cs,
  input  logic        i_a_we,
  input  logic [11:0] i_a_address,
  input  logic [31:0] i_a_write_data,
  input  logic        i_a_lock,
  output logic        o_a_ack,
  output logic [31:0] o_a_read_data,
  input  logic        i_b_cs,
  input  logic        i_b_we,
  input  logic [11:0] i_b_address,
  input  logic [31:0] i_b_write_data,
  input  logic        i_b_lock,
  output logic        o_b_ack,
  output logic [31:0] o_b_read_data,
  output logic        o_api_cs,
  output logic        o_api_we,
  output logic [11:0] o_api_address,
  output logic [31:0] o_api_write_data,
  input  logic [31:0] i_api_read_data
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

  localparam logic [3:0] LAT_M1 = 4'(API_READ_LATENCY - 1);

  state_t      state_reg, state_next;
  logic        grant_reg, grant_next;      // 0 = A, 1 = B
  logic        last_grant_reg;
  logic [3:0]  cnt_reg;
  logic        we_reg;
  logic [11:0] address_reg;
  logic [31:0] write_data_reg;
  logic [31:0] a_read_data_reg;
  logic [31:0] b_read_data_reg;
  logic        grant_valid;
  logic        grant_b;

`ifdef NTS_API_ARBITER_LOCK_EN
  logic owner_valid_reg;
  logic owner_reg;
  logic post_ack_reg;
  logic owner_cs;
  logic owner_lock;
  logic granted_lock;

  assign owner_cs     = owner_reg ? i_b_cs : i_a_cs;
  assign owner_lock   = owner_reg ? i_b_lock : i_a_lock;
  assign granted_lock = grant_reg ? i_b_lock : i_a_lock;
`else
  logic unused_lock;
  assign unused_lock = i_a_lock ^ i_b_lock;
`endif

  always_comb begin
    grant_valid = i_a_cs | i_b_cs;
    grant_b     = i_b_cs & (~i_a_cs | ~last_grant_reg);
`ifdef NTS_API_ARBITER_LOCK_EN
    // The owner must drop cs for one cycle after its ack, so that first IDLE
    // cycle keeps the grant reserved instead of counting as a release.
    if (owner_valid_reg && (post_ack_reg || owner_cs)) begin
      grant_valid = ~post_ack_reg;
      grant_b     = owner_reg;
    end
`endif
  end

  always_ff @(posedge i_clk or negedge i_areset_n) begin
    if (!i_areset_n) begin
      state_reg <= IDLE;
      grant_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      grant_reg <= grant_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    grant_next = grant_reg;
    case (state_reg)
      IDLE: begin
        if (grant_valid) begin
          grant_next = grant_b;
          state_next = ISSUE;
        end
      end
      ISSUE:   state_next = WAIT;
      WAIT:    if (cnt_reg == 4'd0) state_next = ACK;
      ACK:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_areset_n) begin
    if (!i_areset_n) begin
      last_grant_reg  <= 1'b1;
      cnt_reg         <= 4'd0;
      we_reg          <= 1'b0;
      address_reg     <= 12'd0;
      write_data_reg  <= 32'd0;
      a_read_data_reg <= 32'd0;
      b_read_data_reg <= 32'd0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (grant_valid) begin
            we_reg         <= grant_b ? i_b_we         : i_a_we;
            address_reg    <= grant_b ? i_b_address    : i_a_address;
            write_data_reg <= grant_b ? i_b_write_data : i_a_write_data;
          end
        end
        ISSUE: cnt_reg <= LAT_M1;
        WAIT: begin
          if (cnt_reg == 4'd0) begin
            if (!we_reg) begin
              if (grant_reg) b_read_data_reg <= i_api_read_data;
              else           a_read_data_reg <= i_api_read_data;
            end
          end else begin
            cnt_reg <= cnt_reg - 4'd1;
          end
        end
        ACK:     last_grant_reg <= grant_reg;
        default: ;
      endcase
    end
  end

`ifdef NTS_API_ARBITER_LOCK_EN
  always_ff @(posedge i_clk or negedge i_areset_n) begin
    if (!i_areset_n) begin
      owner_valid_reg <= 1'b0;
      owner_reg       <= 1'b0;
      post_ack_reg    <= 1'b0;
    end else begin
      if (state_reg == ACK) begin
        owner_valid_reg <= granted_lock;
        owner_reg       <= grant_reg;
        post_ack_reg    <= 1'b1;
      end else if (state_reg == IDLE) begin
        post_ack_reg <= 1'b0;
        if (owner_valid_reg && !post_ack_reg && !(owner_cs && owner_lock))
          owner_valid_reg <= 1'b0;
      end
    end
  end
`endif

  assign o_api_cs         = (state_reg == ISSUE);
  assign o_api_we         = (state_reg == ISSUE) & we_reg;
  assign o_api_address    = address_reg;
  assign o_api_write_data = write_data_reg;
  assign o_a_ack          = (state_reg == ACK) & ~grant_reg;
  assign o_b_ack          = (state_reg == ACK) & grant_reg;
  assign o_a_read_data    = a_read_data_reg;
  assign o_b_read_data    = b_read_data_reg;

endmodule

// File: tb/tb_nts_api_arbiter.sv
// Directed bench for nts_api_arbiter: reads, writes, round-robin, latency 4,
// reset mid-transaction and grant locking (when NTS_API_ARBITER_LOCK_EN is set).
module tb_nts_api_arbiter;

  logic        clk = 1'b0;
  logic        areset_n;
  logic        a_cs, a_we, a_lock, b_cs, b_we, b_lock, a4_cs;
  logic [11:0] a_addr, b_addr;
  logic [31:0] a_wdata, b_wdata, api_rdata;
  logic        a_ack, b_ack, api_cs, api_we;
  logic [31:0] a_rdata, b_rdata, api_wdata;
  logic [11:0] api_addr;
  logic        d4_a_ack, d4_b_ack, d4_api_cs, d4_api_we;
  logic [31:0] d4_a_rdata, d4_b_rdata, d4_api_wdata;
  logic [11:0] d4_api_addr;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  nts_api_arbiter #(.API_READ_LATENCY(1)) dut (
    .i_clk(clk), .i_areset_n(areset_n),
    .i_a_cs(a_cs), .i_a_we(a_we), .i_a_address(a_addr), .i_a_write_data(a_wdata),
    .i_a_lock(a_lock), .o_a_ack(a_ack), .o_a_read_data(a_rdata),
    .i_b_cs(b_cs), .i_b_we(b_we), .i_b_address(b_addr), .i_b_write_data(b_wdata),
    .i_b_lock(b_lock), .o_b_ack(b_ack), .o_b_read_data(b_rdata),
    .o_api_cs(api_cs), .o_api_we(api_we), .o_api_address(api_addr),
    .o_api_write_data(api_wdata), .i_api_read_data(api_rdata)
  );

  nts_api_arbiter #(.API_READ_LATENCY(4)) dut4 (
    .i_clk(clk), .i_areset_n(areset_n),
    .i_a_cs(a4_cs), .i_a_we(a_we), .i_a_address(a_addr), .i_a_write_data(a_wdata),
    .i_a_lock(1'b0), .o_a_ack(d4_a_ack), .o_a_read_data(d4_a_rdata),
    .i_b_cs(1'b0), .i_b_we(1'b0), .i_b_address(12'h000), .i_b_write_data(32'h0),
    .i_b_lock(1'b0), .o_b_ack(d4_b_ack), .o_b_read_data(d4_b_rdata),
    .o_api_cs(d4_api_cs), .o_api_we(d4_api_we), .o_api_address(d4_api_addr),
    .o_api_write_data(d4_api_wdata), .i_api_read_data(api_rdata)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance until the shared API is selected (bounded), then check the address.
  task automatic wait_issue(input string tag, input logic [11:0] exp_addr);
    int n = 0;
    while (!api_cs && n < 20) begin
      tick();
      n++;
    end
    check({tag, " issue"}, 32'(api_cs), 32'd1);
    check({tag, " addr"}, 32'(api_addr), 32'(exp_addr));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic exp_b [4];
    logic win_b;
    int   ai;

    areset_n = 1'b0;
    a_cs = 0; a_we = 0; a_lock = 0; a_addr = '0; a_wdata = '0;
    b_cs = 0; b_we = 0; b_lock = 0; b_addr = '0; b_wdata = '0;
    a4_cs = 0; api_rdata = 32'h1111_1111;
    repeat (2) tick();
    check("reset api_cs", 32'(api_cs), 32'd0);
    check("reset api_addr", 32'(api_addr), 32'd0);
    check("reset acks", 32'({a_ack, b_ack}), 32'd0);
    check("reset a_rdata", a_rdata, 32'd0);
    areset_n = 1'b1;
    tick();

    // Single read by A, data valid only in cycle 2
    a_we = 0; a_addr = 12'h010; a_cs = 1;
    check("rd c0 api_cs", 32'(api_cs), 32'd0);
    tick();
    check("rd c1 api_cs", 32'(api_cs), 32'd1);
    check("rd c1 api_we", 32'(api_we), 32'd0);
    check("rd c1 addr", 32'(api_addr), 32'h010);
    tick();
    api_rdata = 32'hDEAD_BEEF;
    check("rd c2 api_cs", 32'(api_cs), 32'd0);
    check("rd c2 a_ack", 32'(a_ack), 32'd0);
    tick();
    api_rdata = 32'h1111_1111;
    check("rd c3 a_ack", 32'(a_ack), 32'd1);
    check("rd c3 b_ack", 32'(b_ack), 32'd0);
    check("rd c3 a_rdata", a_rdata, 32'hDEAD_BEEF);
    check("rd c3 b_rdata", b_rdata, 32'd0);
    a_cs = 0;
    $display("txn read A addr=010 data=%h", a_rdata);
    tick();
    check("rd c4 a_ack", 32'(a_ack), 32'd0);

    // Single write by B
    b_we = 1; b_addr = 12'h085; b_wdata = 32'h1234_5678; b_cs = 1;
    tick();
    check("wr c1 api_cs", 32'(api_cs), 32'd1);
    check("wr c1 api_we", 32'(api_we), 32'd1);
    check("wr c1 addr", 32'(api_addr), 32'h085);
    check("wr c1 wdata", api_wdata, 32'h1234_5678);
    tick();
    check("wr c2 api_cs/we", 32'({api_cs, api_we}), 32'd0);
    tick();
    check("wr c3 b_ack", 32'(b_ack), 32'd1);
    check("wr c3 a_ack", 32'(a_ack), 32'd0);
    check("wr c3 b_rdata", b_rdata, 32'd0);
    check("wr c3 a_rdata", a_rdata, 32'hDEAD_BEEF);
    b_cs = 0; b_we = 0;
    $display("txn write B addr=085 data=12345678");
    tick();

    // Contention: expect A, B, A, B
    a_addr = 12'h100; b_addr = 12'h200; a_cs = 1; b_cs = 1;
    for (int k = 0; k < 4; k++) begin
      win_b = k[0];
      tick();
      check("rr issue", 32'(api_cs), 32'd1);
      check("rr addr", 32'(api_addr), win_b ? 32'h200 : 32'h100);
      check("rr acks issue", 32'({a_ack, b_ack}), 32'd0);
      tick();
      api_rdata = 32'hC0DE_0000 + 32'(k);
      check("rr acks wait", 32'({a_ack, b_ack}), 32'd0);
      tick();
      check("rr acks", 32'({a_ack, b_ack}), win_b ? 32'd1 : 32'd2);
      check("rr rdata", win_b ? b_rdata : a_rdata, 32'hC0DE_0000 + 32'(k));
      $display("txn rr %0d winner=%s", k, win_b ? "B" : "A");
      if (win_b) b_cs = 0; else a_cs = 0;
      tick();
      check("rr acks idle", 32'({a_ack, b_ack}), 32'd0);
      if (k < 2) begin
        if (win_b) b_cs = 1; else a_cs = 1;
      end
    end

    // Read latency 4 on the second instance
    a_we = 0; a_addr = 12'h3F0; a4_cs = 1;
    tick();
    check("l4 c1 api_cs", 32'(d4_api_cs), 32'd1);
    for (int c = 2; c <= 5; c++) begin
      tick();
      api_rdata = (c == 5) ? 32'h4444_AAAA : 32'hBAD0_0000 + 32'(c);
      check("l4 wait api_cs", 32'(d4_api_cs), 32'd0);
      check("l4 wait ack", 32'(d4_a_ack), 32'd0);
    end
    tick();
    check("l4 c6 ack", 32'(d4_a_ack), 32'd1);
    check("l4 c6 rdata", d4_a_rdata, 32'h4444_AAAA);
    a4_cs = 0;
    $display("txn L4 read A data=%h", d4_a_rdata);
    tick();
    check("l4 c7 ack", 32'(d4_a_ack), 32'd0);

    // A write so last_grant is A, then B read aborted by reset in WAIT
    a_we = 1; a_addr = 12'h055; a_wdata = 32'hA5A5_A5A5; a_cs = 1;
    repeat (3) tick();
    check("pre-rst a_ack", 32'(a_ack), 32'd1);
    a_cs = 0; a_we = 0;
    tick();
    b_we = 0; b_addr = 12'h0C3; b_cs = 1;
    tick();
    check("rst issue addr", 32'(api_addr), 32'h0C3);
    tick();
    api_rdata = 32'h9999_9999;
    areset_n = 1'b0;
    #1;
    check("rst api_addr", 32'(api_addr), 32'd0);
    check("rst api_wdata", api_wdata, 32'd0);
    check("rst rdata", a_rdata | b_rdata, 32'd0);
    check("rst acks", 32'({a_ack, b_ack, api_cs}), 32'd0);
    tick();
    check("rst hold acks", 32'({a_ack, b_ack}), 32'd0);
    b_cs = 0;
    areset_n = 1'b1;
    tick();
    check("post-rst b_ack", 32'(b_ack), 32'd0);
    check("post-rst b_rdata", b_rdata, 32'd0);
    $display("txn reset dropped B read");

    // Tie after reset: A must win, then B
    a_addr = 12'h0A1; b_addr = 12'h0B1; a_cs = 1; b_cs = 1;
    tick();
    check("tie addr A", 32'(api_addr), 32'h0A1);
    repeat (2) tick();
    check("tie a_ack", 32'(a_ack), 32'd1);
    a_cs = 0;
    repeat (2) tick();
    check("tie addr B", 32'(api_addr), 32'h0B1);
    repeat (2) tick();
    check("tie b_ack", 32'(b_ack), 32'd1);
    b_cs = 0;
    tick();

    // Lock: A issues three reads (lock on first two) while B requests
`ifdef NTS_API_ARBITER_LOCK_EN
    exp_b[0] = 0; exp_b[1] = 0; exp_b[2] = 0; exp_b[3] = 1;
`else
    exp_b[0] = 0; exp_b[1] = 1; exp_b[2] = 0; exp_b[3] = 0;
`endif
    ai = 0;
    a_addr = 12'h020; a_lock = 1; a_cs = 1; b_addr = 12'h0B0; b_cs = 1;
    for (int k = 0; k < 4; k++) begin
      wait_issue("lock", exp_b[k] ? 12'h0B0 : 12'h020 + 12'(ai));
      win_b = (api_addr == 12'h0B0);
      repeat (2) tick();
      check("lock ack", 32'({a_ack, b_ack}), win_b ? 32'd1 : 32'd2);
      $display("txn lock %0d winner=%s addr=%h", k, win_b ? "B" : "A", api_addr);
      if (win_b) b_cs = 0;
      else begin
        a_cs = 0;
        ai++;
      end
      tick();
      if (!win_b && ai < 3) begin
        tick();
        a_addr = 12'h020 + 12'(ai); a_lock = (ai < 2); a_cs = 1;
      end
    end
    a_cs = 0; b_cs = 0; a_lock = 0;
    repeat (4) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
